// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: decoder
// encodings, controller state, and the NOP image loaded by bubbles/flushes.
package pipeline_hazard_ctrl_pkg;

  // Register address width used by the decoder (DA/AA/BA).
  localparam int REG_ADDRESS_SIZE = 3;

  // MUXD select value that marks a load (data memory to register file).
  localparam logic [1:0] MD_LOAD = 2'b01;

  // Controller state: normal sequencing, or holding for a slow data access.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  // Scoreboard-visible control bits of an instruction held in a stage.
  typedef struct packed {
    logic wr;   // writes the register file
    logic mem;  // accesses data memory in EX
  } stage_ctrl_t;

  // NOP instruction as seen by the IF/ID flush and ID/EX bubble logic:
  // no register write and no memory access.
  localparam stage_ctrl_t STAGE_NOP = '{wr: 1'b0, mem: 1'b0};

  // An instruction touches data memory if it stores or loads.
  function automatic logic is_mem_op(input logic mw, input logic [1:0] md);
    return mw | (md == MD_LOAD);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Two-entry scoreboard of in-flight register writes (EX and WB stages) and
// the read-after-write comparators for the instruction sitting in ID.
module hazard_scoreboard #(
  parameter int REG_ADDRESS_SIZE = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        idex_en_i,     // ID/EX stage register loads
  input  logic                        idex_bubble_i, // load a NOP instead of ID
  input  logic                        exwb_en_i,     // EX/WB stage register loads
  input  logic                        id_valid_i,
  input  logic [REG_ADDRESS_SIZE-1:0] id_da_i,
  input  logic [REG_ADDRESS_SIZE-1:0] id_aa_i,
  input  logic [REG_ADDRESS_SIZE-1:0] id_ba_i,
  input  logic                        id_rw_i,
  input  logic                        id_mw_i,
  input  logic [1:0]                  id_md_i,
  input  logic                        id_rd_a_i,
  input  logic                        id_rd_b_i,
  output logic                        ex_mem_o,      // EX holds a memory op
  output logic                        raw_o          // ID must wait for a write
);
  import pipeline_hazard_ctrl_pkg::*;

  logic                        ex_wr_q,  ex_wr_d;
  logic                        ex_mem_q, ex_mem_d;
  logic [REG_ADDRESS_SIZE-1:0] ex_da_q,  ex_da_d;
  logic                        wb_wr_q,  wb_wr_d;
  logic [REG_ADDRESS_SIZE-1:0] wb_da_q,  wb_da_d;

  // A source register is busy while an older instruction still has to write it.
  // Register 0 is an ordinary register, and there is no forwarding path.
  function automatic logic hit(input logic [REG_ADDRESS_SIZE-1:0] addr);
    return (ex_wr_q & (ex_da_q == addr)) | (wb_wr_q & (wb_da_q == addr));
  endfunction

  // Hazard detection for the instruction currently decoded in ID.
  always_comb begin
    raw_o = id_valid_i & ((id_rd_a_i & hit(id_aa_i)) | (id_rd_b_i & hit(id_ba_i)));
  end

  assign ex_mem_o = ex_mem_q;

  // Next-state of the EX and WB destination entries.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    ex_wr_d  = ex_wr_q;
    ex_mem_d = ex_mem_q;
    ex_da_d  = ex_da_q;
    wb_wr_d  = wb_wr_q;
    wb_da_d  = wb_da_q;

    if (idex_en_i) begin
      if (idex_bubble_i) begin
        ex_wr_d  = STAGE_NOP.wr;
        ex_mem_d = STAGE_NOP.mem;
      end else begin
        ex_wr_d  = id_valid_i & id_rw_i;
        ex_da_d  = id_da_i;
        ex_mem_d = id_valid_i & is_mem_op(id_mw_i, id_md_i);
      end
    end

    if (exwb_en_i) begin
      wb_wr_d = ex_wr_q;
      wb_da_d = ex_da_q;
    end
  end

  // Scoreboard registers; valid bits clear on reset so nothing is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_wr_q  <= 1'b0;
      ex_mem_q <= 1'b0;
      ex_da_q  <= '0;
      wb_wr_q  <= 1'b0;
      wb_da_q  <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values, independent of statement order.
      ex_wr_q  <= ex_wr_d;
      ex_mem_q <= ex_mem_d;
      ex_da_q  <= ex_da_d;
      wb_wr_q  <= wb_wr_d;
      wb_da_q  <= wb_da_d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the IF/ID/EX/WB pipeline: drives stage enables,
// IF/ID flush and ID/EX bubble from RAW hazards, taken branches and data
// memory waits, and counts stalled cycles.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDRESS_SIZE = pipeline_hazard_ctrl_pkg::REG_ADDRESS_SIZE,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [REG_ADDRESS_SIZE-1:0] id_DA,
  input  logic [REG_ADDRESS_SIZE-1:0] id_AA,
  input  logic [REG_ADDRESS_SIZE-1:0] id_BA,
  input  logic                        id_RW,
  input  logic                        id_MW,
  input  logic [1:0]                  id_MD,
  input  logic                        id_rd_a,
  input  logic                        id_rd_b,
  input  logic                        ex_br_taken,
  input  logic                        dmem_ack,
  output logic                        pc_en,
  output logic                        ifid_en,
  output logic                        exwb_en,
  output logic                        ifid_flush,
  output logic                        idex_bubble,
  output logic                        dmem_req,
  output logic [CNT_WIDTH-1:0]        stall_cnt
);
  import pipeline_hazard_ctrl_pkg::*;

  state_e               state_q;
  logic                 ex_mem;
  logic                 raw;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // ID/EX advances exactly when EX moves on to WB; a bubble then loads a NOP.
  hazard_scoreboard #(
    .REG_ADDRESS_SIZE (REG_ADDRESS_SIZE)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .idex_en_i     (exwb_en),
    .idex_bubble_i (idex_bubble),
    .exwb_en_i     (exwb_en),
    .id_valid_i    (id_valid),
    .id_da_i       (id_DA),
    .id_aa_i       (id_AA),
    .id_ba_i       (id_BA),
    .id_rw_i       (id_RW),
    .id_mw_i       (id_MW),
    .id_md_i       (id_MD),
    .id_rd_a_i     (id_rd_a),
    .id_rd_b_i     (id_rd_b),
    .ex_mem_o      (ex_mem),
    .raw_o         (raw)
  );

  // Pipeline controls, combinational from state, scoreboard and inputs.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    exwb_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    dmem_req    = ex_mem;

    case (state_q)
      RUN: begin
        if (ex_mem & ~dmem_ack) begin
          // Slow access: freeze every stage, ID/EX keeps its instruction.
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          exwb_en = 1'b0;
        end else if (ex_br_taken) begin
          // Squash the two wrong-path slots; any RAW in ID dies with them.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (raw) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (!dmem_ack) begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          exwb_en = 1'b0;
        end else if (raw) begin
          // Ack cycle: the pipeline moves again, RAW still applies to ID.
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      default: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        exwb_en = 1'b0;
      end
    endcase
  end

  // Controller FSM: leave RUN when an EX memory op is not acked at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:      if (ex_mem & ~dmem_ack) state_q <= MEM_WAIT;
        MEM_WAIT: if (dmem_ack)           state_q <= RUN;
        default:                          state_q <= RUN;
      endcase
    end
  end

  // Stall counter next value: count frozen-PC cycles, stop at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic,
// all checked against an in-flight-instruction model of the pipeline.
module tb_pipeline_hazard_ctrl;

  localparam int RW  = 3;
  localparam int CW  = 16;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [RW-1:0] id_DA, id_AA, id_BA;
  logic          id_RW, id_MW;
  logic [1:0]    id_MD;
  logic          id_rd_a, id_rd_b;
  logic          ex_br_taken, dmem_ack;
  logic          pc_en, ifid_en, exwb_en, ifid_flush, idex_bubble, dmem_req;
  logic [CW-1:0] stall_cnt;

  pipeline_hazard_ctrl #(.REG_ADDRESS_SIZE(RW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_DA(id_DA), .id_AA(id_AA), .id_BA(id_BA),
    .id_RW(id_RW), .id_MW(id_MW), .id_MD(id_MD),
    .id_rd_a(id_rd_a), .id_rd_b(id_rd_b),
    .ex_br_taken(ex_br_taken), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .exwb_en(exwb_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .dmem_req(dmem_req), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] da, aa, ba;
    logic          rw, mw;
    logic [1:0]    md;
    logic          rd_a, rd_b, br, ack;
  } stim_t;

  // What the pipeline should do in one cycle.
  typedef struct packed {
    logic pc, ifid, exwb, flush, bubble, req;
  } ctrl_t;

  // One instruction in flight: does it write, where, does it touch memory.
  typedef struct {
    bit wr;
    int da;
    bit mem;
  } slot_t;

  slot_t inflight[2];  // [0] = instruction in EX, [1] = instruction in WB
  int    m_stalls;
  int    n_checks = 0;
  int    n_pass   = 0;
  ctrl_t o;            // DUT controls sampled in the last step

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) inflight[i] = '{wr: 1'b0, da: 0, mem: 1'b0};
    m_stalls = 0;
  endfunction

  // Register x still has a write pending in EX or WB.
  function automatic bit pending(input int x);
    for (int i = 0; i < 2; i++)
      if (inflight[i].wr && inflight[i].da == x) return 1'b1;
    return 1'b0;
  endfunction

  // Expected controls: an unacked memory op freezes everything; otherwise a
  // taken branch squashes two slots; otherwise a RAW holds IF/ID and bubbles.
  function automatic ctrl_t model_eval(input stim_t s);
    ctrl_t e;
    bit    raw_h;
    raw_h = s.valid && ((s.rd_a && pending(int'(s.aa))) || (s.rd_b && pending(int'(s.ba))));
    e.req = inflight[0].mem;
    if (inflight[0].mem && !s.ack) begin
      e.pc = 0; e.ifid = 0; e.exwb = 0; e.flush = 0; e.bubble = 0;
    end else if (s.br) begin
      e.pc = 1; e.ifid = 1; e.exwb = 1; e.flush = 1; e.bubble = 1;
    end else if (raw_h) begin
      e.pc = 0; e.ifid = 0; e.exwb = 1; e.flush = 0; e.bubble = 1;
    end else begin
      e.pc = 1; e.ifid = 1; e.exwb = 1; e.flush = 0; e.bubble = 0;
    end
    return e;
  endfunction

  function automatic void model_update(input stim_t s, input ctrl_t e);
    if (e.exwb) begin
      inflight[1] = inflight[0];
      if (e.bubble) inflight[0] = '{wr: 1'b0, da: 0, mem: 1'b0};
      else inflight[0] = '{wr: s.valid && s.rw, da: int'(s.da),
                           mem: s.valid && (s.mw || s.md == 2'b01)};
    end
    if (!e.pc && m_stalls < SAT) m_stalls++;
  endfunction

  // One clock: called just after a rising edge, returns just after the next.
  task automatic step(input stim_t s, input bit chk);
    ctrl_t e;
    id_valid = s.valid; id_DA = s.da; id_AA = s.aa; id_BA = s.ba;
    id_RW = s.rw; id_MW = s.mw; id_MD = s.md;
    id_rd_a = s.rd_a; id_rd_b = s.rd_b; ex_br_taken = s.br; dmem_ack = s.ack;
    @(negedge clk);
    e = model_eval(s);
    o = '{pc: pc_en, ifid: ifid_en, exwb: exwb_en, flush: ifid_flush,
          bubble: idex_bubble, req: dmem_req};
    if (chk) begin
      check("pc_en",       32'(pc_en),       32'(e.pc));
      check("ifid_en",     32'(ifid_en),     32'(e.ifid));
      check("exwb_en",     32'(exwb_en),     32'(e.exwb));
      check("ifid_flush",  32'(ifid_flush),  32'(e.flush));
      check("idex_bubble", 32'(idex_bubble), 32'(e.bubble));
      check("dmem_req",    32'(dmem_req),    32'(e.req));
      check("stall_cnt",   32'(stall_cnt),   32'(m_stalls));
    end
    model_update(s, e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t bubble_op();
    return '0;
  endfunction

  function automatic stim_t alu(input int dst, input int a, input int b,
                                input bit use_a, input bit use_b);
    stim_t s = '0;
    s.valid = 1'b1; s.rw = 1'b1; s.da = RW'(dst); s.aa = RW'(a); s.ba = RW'(b);
    s.rd_a = use_a; s.rd_b = use_b;
    return s;
  endfunction

  function automatic stim_t load(input int dst);
    stim_t s = alu(dst, 0, 0, 1'b0, 1'b0);
    s.md = 2'b01;
    return s;
  endfunction

  initial begin
    stim_t s;
    int    cnt_a, cnt_b;

    rst_n = 1'b0;
    id_valid = 0; id_DA = 0; id_AA = 0; id_BA = 0; id_RW = 0; id_MW = 0;
    id_MD = 0; id_rd_a = 0; id_rd_b = 0; ex_br_taken = 0; dmem_ack = 0;
    model_clear();
    #2;
    check("rst_pc_en",     32'(pc_en),       32'd1);
    check("rst_ifid_en",   32'(ifid_en),     32'd1);
    check("rst_exwb_en",   32'(exwb_en),     32'd1);
    check("rst_flush",     32'(ifid_flush),  32'd0);
    check("rst_bubble",    32'(idex_bubble), 32'd0);
    check("rst_dmem_req",  32'(dmem_req),    32'd0);
    check("rst_stall_cnt", 32'(stall_cnt),   32'd0);
    @(posedge clk); #1;
    do_reset();

    // Back-to-back RAW on the EX destination: two bubbles.
    step(alu(1, 0, 0, 0, 0), 1'b1);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 3; i++) begin
      step(alu(2, 1, 3, 1, 1), 1'b1);
      cnt_a += int'(o.bubble);
      cnt_b += int'(!o.pc);
    end
    check("raw_ex_bubbles", 32'(cnt_a), 32'd2);
    check("raw_ex_pc_off",  32'(cnt_b), 32'd2);
    check("raw_ex_stalls",  32'(stall_cnt), 32'd2);

    // RAW on the WB destination: one bubble.
    do_reset();
    step(alu(4, 0, 0, 0, 0), 1'b1);
    step(alu(6, 7, 0, 1, 0), 1'b1);
    cnt_a = 0;
    for (int i = 0; i < 2; i++) begin
      step(alu(2, 4, 0, 1, 0), 1'b1);
      cnt_a += int'(o.bubble);
    end
    check("raw_wb_bubbles", 32'(cnt_a), 32'd1);

    // Taken branch overrides a RAW in ID.
    do_reset();
    step(alu(5, 0, 0, 0, 0), 1'b1);
    s = alu(1, 5, 5, 1, 1); s.br = 1'b1;
    step(s, 1'b1);
    check("br_flush",  32'(o.flush),  32'd1);
    check("br_bubble", 32'(o.bubble), 32'd1);
    check("br_pc_en",  32'(o.pc),     32'd1);
    check("br_stalls", 32'(stall_cnt), 32'd0);

    // Load acked three cycles after the first request, then a zero-wait load.
    do_reset();
    step(load(3), 1'b1);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 4; i++) begin
      s = alu(6, 7, 0, 1, 0); s.ack = (i == 3);
      step(s, 1'b1);
      cnt_a += int'(o.req);
      cnt_b += int'(!o.pc && !o.ifid && !o.exwb);
    end
    check("ld_req_cycles",  32'(cnt_a), 32'd4);
    check("ld_frozen",      32'(cnt_b), 32'd3);
    check("ld_stalls",      32'(stall_cnt), 32'd3);
    step(load(2), 1'b1);
    s = bubble_op(); s.ack = 1'b1;
    step(s, 1'b1);
    check("ld0_req",    32'(o.req), 32'd1);
    check("ld0_pc_en",  32'(o.pc),  32'd1);
    check("ld0_stalls", 32'(stall_cnt), 32'd3);

    // Reset in the middle of a memory wait.
    do_reset();
    step(load(3), 1'b1);
    step(bubble_op(), 1'b1);
    step(bubble_op(), 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstw_dmem_req",  32'(dmem_req),  32'd0);
    check("rstw_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rstw_pc_en",     32'(pc_en),     32'd1);
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(alu(1, 3, 3, 1, 1), 1'b1);
    check("rstw_no_hazard", 32'(o.bubble), 32'd0);

    // Long memory wait saturates the stall counter.
    do_reset();
    step(load(7), 1'b1);
    for (int i = 0; i < SAT + 6; i++) step(bubble_op(), 1'b0);
    check("sat_stall_cnt", 32'(stall_cnt), 32'(SAT));
    s = bubble_op(); s.ack = 1'b1;
    step(s, 1'b1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      s.valid = ($urandom_range(0, 3) != 0);
      s.da    = RW'($urandom_range(0, 7));
      s.aa    = RW'($urandom_range(0, 7));
      s.ba    = RW'($urandom_range(0, 7));
      s.rw    = 1'($urandom_range(0, 1));
      s.mw    = ($urandom_range(0, 5) == 0);
      s.md    = 2'($urandom_range(0, 3));
      s.rd_a  = 1'($urandom_range(0, 1));
      s.rd_b  = 1'($urandom_range(0, 1));
      // Branches never sit in EX together with a memory op.
      s.br    = ($urandom_range(0, 7) == 0) && !inflight[0].mem;
      s.ack   = ($urandom_range(0, 2) == 0);
      step(s, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
